// File: rtl/sam_sched_ctrl_if.sv
// Handshake/config bundle between a frame controller and the sample scheduler.
// Ports: start/stop pulses and div/sps/nsym config in; sample/symbol strobes,
// indices and frame status out. The master drives control; the slave is the scheduler.
interface sam_sched_ctrl_if #(
    parameter int CNT_W = 16,
    parameter int SPS_W = 4,
    parameter int FRM_W = 12
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] div_cfg;
    logic [SPS_W-1:0] sps_cfg;
    logic [FRM_W-1:0] nsym_cfg;
    logic             sam_en;
    logic             sym_en;
    logic [SPS_W-1:0] sam_idx;
    logic [FRM_W-1:0] sym_cnt;
    logic             busy;
    logic             done;
    logic             cfg_err;

    modport master (
        output start, stop, div_cfg, sps_cfg, nsym_cfg,
        input  sam_en, sym_en, sam_idx, sym_cnt, busy, done, cfg_err
    );

    modport slave (
        input  start, stop, div_cfg, sps_cfg, nsym_cfg,
        output sam_en, sym_en, sam_idx, sym_cnt, busy, done, cfg_err
    );
endinterface

// File: rtl/sam_sched_ctrl.sv
// Sample/symbol/frame strobe sequencer for one QPSK frame (clock-enable generator).
// Latency: busy rises 1 edge after start; first sam_en div edges later; done 1 edge after last strobe.
// Backpressure: none; strobes free-run once started, stop aborts, start ignored while busy.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries start/stop, div/sps/nsym
// config, and the sam_en/sym_en strobes, sam_idx/sym_cnt indices, busy/done/cfg_err status.
module sam_sched_ctrl #(
    parameter int CNT_W   = 16,
    parameter int SPS_W   = 4,
    parameter int FRM_W   = 12,
    parameter int DEF_DIV = 100
) (
    input  logic                clk,
    input  logic                rst,
    sam_sched_ctrl_if.slave     bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [SPS_W-1:0] SPS_ONE = SPS_W'(1);
    localparam logic [FRM_W-1:0] FRM_ONE = FRM_W'(1);

    logic [0:0]       state;
    logic [CNT_W-1:0] div_q;
    logic [SPS_W-1:0] sps_q;
    logic [FRM_W-1:0] nsym_q;
    logic [CNT_W-1:0] div_cnt;
    // Index the next strobe will carry; sam_idx only shows it once the strobe fires.
    logic [SPS_W-1:0] idx_next;

    logic [CNT_W-1:0] div_sel;
    logic             cfg_ok;
    logic             start_ok;
    logic             start_bad;
    logic             div_wrap;
    logic             sym_last;
    logic             frame_end;

    always_comb begin
        div_sel = bus.div_cfg;
        if (bus.div_cfg == '0) begin
            div_sel = CNT_W'(DEF_DIV);
        end else if (bus.div_cfg == CNT_ONE) begin
            // A divide of 1 would leave no idle cycle between strobes.
            div_sel = CNT_W'(2);
        end
    end

    assign cfg_ok    = (bus.sps_cfg != '0) && (bus.nsym_cfg != '0);
    // stop wins over a coincident start, so neither a frame nor cfg_err results.
    assign start_ok  = bus.start && !bus.stop && cfg_ok;
    assign start_bad = bus.start && !bus.stop && !cfg_ok;
    assign div_wrap  = (div_cnt == div_q - CNT_ONE);
    assign sym_last  = (idx_next == sps_q - SPS_ONE);
    // The final strobe is visible on the registered outputs; the frame ends on the edge after.
    assign frame_end = bus.sym_en && (bus.sym_cnt == nsym_q - FRM_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            div_q       <= '0;
            sps_q       <= '0;
            nsym_q      <= '0;
            div_cnt     <= '0;
            idx_next    <= '0;
            bus.sam_en  <= 1'b0;
            bus.sym_en  <= 1'b0;
            bus.sam_idx <= '0;
            bus.sym_cnt <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.cfg_err <= 1'b0;
        end else begin
            bus.sam_en  <= 1'b0;
            bus.sym_en  <= 1'b0;
            bus.done    <= 1'b0;
            bus.cfg_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state       <= ST_RUN;
                        bus.busy    <= 1'b1;
                        div_q       <= div_sel;
                        sps_q       <= bus.sps_cfg;
                        nsym_q      <= bus.nsym_cfg;
                        div_cnt     <= '0;
                        idx_next    <= '0;
                        bus.sam_idx <= '0;
                        bus.sym_cnt <= '0;
                    end else if (start_bad) begin
                        bus.cfg_err <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (bus.stop || frame_end) begin
                        // Abort and normal completion clear identically; only done differs.
                        state       <= ST_IDLE;
                        bus.busy    <= 1'b0;
                        bus.done    <= !bus.stop;
                        div_cnt     <= '0;
                        idx_next    <= '0;
                        bus.sam_idx <= '0;
                        bus.sym_cnt <= '0;
                    end else begin
                        if (bus.sym_en) begin
                            bus.sym_cnt <= bus.sym_cnt + FRM_ONE;
                        end
                        if (div_wrap) begin
                            div_cnt     <= '0;
                            bus.sam_en  <= 1'b1;
                            bus.sym_en  <= sym_last;
                            bus.sam_idx <= idx_next;
                            idx_next    <= sym_last ? '0 : idx_next + SPS_ONE;
                        end else begin
                            div_cnt <= div_cnt + CNT_ONE;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sam_sched_ctrl.sv
// Directed + randomized bench for sam_sched_ctrl against an arithmetic frame-timing model.
module tb_sam_sched_ctrl;
    localparam int CNT_W = 16;
    localparam int SPS_W = 4;
    localparam int FRM_W = 12;
    localparam int OW    = 5 + SPS_W + FRM_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    sam_sched_ctrl_if #(.CNT_W(CNT_W), .SPS_W(SPS_W), .FRM_W(FRM_W)) bus ();

    sam_sched_ctrl #(
        .CNT_W  (CNT_W),
        .SPS_W  (SPS_W),
        .FRM_W  (FRM_W),
        .DEF_DIV(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #10 clk = ~clk;

    // {busy, sam_en, sym_en, done, cfg_err, sam_idx, sym_cnt}
    function automatic logic [OW-1:0] obs_vec();
        return {bus.busy, bus.sam_en, bus.sym_en, bus.done, bus.cfg_err, bus.sam_idx, bus.sym_cnt};
    endfunction

    function automatic logic [OW-1:0] pack(input bit b, input bit sa, input bit sy,
                                           input bit d, input bit e, input int idx, input int cnt);
        return {b, sa, sy, d, e, SPS_W'(idx), FRM_W'(cnt)};
    endfunction

    // Expected outputs t edges after busy rose: strobe k lands at k*div, carries
    // sample (k-1)%sps of symbol (k-1)/sps, and done lands one edge after the last strobe.
    function automatic logic [OW-1:0] model(input int t, input int div, input int sps, input int nsym);
        int  n_end;
        bit  b, sa, sy, d;
        int  idx, cnt;
        n_end = sps * nsym * div;
        b   = (t <= n_end);
        sa  = (t > 0) && (t % div == 0) && (t <= n_end);
        sy  = sa && ((t / div) % sps == 0);
        idx = (t >= div && t <= n_end) ? ((t / div) - 1) % sps : 0;
        cnt = (t >= 1 && t <= n_end) ? ((t - 1) / div) / sps : 0;
        d   = (t == n_end + 1);
        return pack(b, sa, sy, d, 1'b0, idx, cnt);
    endfunction

    task automatic check(input string tag, input int t, input logic [OW-1:0] exp);
        logic [OW-1:0] o;
        o = obs_vec();
        checks++;
        assert (o === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, o, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check(tag, i, '0);
        end
    endtask

    // abort_t > 0: stop (or rst) is held in the cycle before edge abort_t.
    // poke_t >= 0: an extra start pulse during RUN that must be ignored.
    task automatic run_frame(input string tag, input int dcfg, input int scfg, input int ncfg,
                             input int abort_t, input bit use_rst, input int poke_t);
        int div, n_end, last;
        div   = (dcfg == 0) ? 100 : (dcfg == 1) ? 2 : dcfg;
        n_end = scfg * ncfg * div;
        last  = (abort_t > 0) ? abort_t - 1 : n_end + 1;
        bus.div_cfg  = CNT_W'(dcfg);
        bus.sps_cfg  = SPS_W'(scfg);
        bus.nsym_cfg = FRM_W'(ncfg);
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        // Config churn while running must not matter.
        bus.div_cfg  = CNT_W'($urandom);
        bus.sps_cfg  = SPS_W'($urandom);
        bus.nsym_cfg = FRM_W'($urandom);
        for (int t = 0; t <= last; t++) begin
            check(tag, t, model(t, div, scfg, ncfg));
            if (t == poke_t) bus.start = 1'b1;
            if (t < last) begin
                tick();
                bus.start = 1'b0;
            end
        end
        if (abort_t > 0) begin
            if (use_rst) rst = 1'b1;
            else bus.stop = 1'b1;
            tick();
            rst      = 1'b0;
            bus.stop = 1'b0;
            check({tag, "_abort"}, abort_t, '0);
            idle({tag, "_after_abort"}, 2 * div);
        end
    endtask

    initial begin
        int dcfg, scfg, ncfg, n_end, ab;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.div_cfg  = '0;
        bus.sps_cfg  = '0;
        bus.nsym_cfg = '0;

        // Reset state
        tick(); tick(); tick();
        check("reset", 0, '0);
        rst = 1'b0;
        idle("post_reset", 2);

        // Nominal frame, then two frames started back-to-back in the done cycle
        run_frame("f100_4_3", 100, 4, 3, 0, 1'b0, -1);
        run_frame("fdef_1_2", 0, 1, 2, 0, 1'b0, -1);
        run_frame("fclamp_2_1", 1, 2, 1, 0, 1'b0, -1);
        idle("after_clamp", 3);

        // Stop coinciding with the 7th strobe, with a stray start mid-frame
        run_frame("fstop7", 10, 4, 5, 70, 1'b0, 15);

        // Bad config rejections
        bus.sps_cfg = '0; bus.nsym_cfg = 12'd3; bus.div_cfg = 16'd5; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("cfg_err_sps0", 0, pack(0, 0, 0, 0, 1, 0, 0));
        tick();
        check("cfg_err_clear", 1, '0);
        bus.sps_cfg = 4'd2; bus.nsym_cfg = '0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("cfg_err_nsym0", 0, pack(0, 0, 0, 0, 1, 0, 0));
        idle("cfg_err_idle", 2);

        // start+stop in IDLE, and bad config with stop: nothing happens
        bus.nsym_cfg = 12'd2; bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        check("start_stop_idle", 0, '0);
        idle("start_stop_idle_after", 3);
        bus.sps_cfg = '0; bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        check("bad_start_stop", 0, '0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("stop_idle", 0, '0);

        // Reset mid-frame after three strobes, then a clean frame
        run_frame("frst", 10, 4, 3, 34, 1'b1, -1);
        run_frame("frst_fresh", 10, 4, 3, 0, 1'b0, -1);
        idle("frst_fresh_idle", 2);

        // Randomized frames, some aborted by stop at a random edge
        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 9))
                0:       dcfg = 0;
                1:       dcfg = 1;
                default: dcfg = $urandom_range(2, 12);
            endcase
            scfg  = ($urandom_range(0, 5) == 0) ? 15 : $urandom_range(1, 4);
            ncfg  = $urandom_range(1, 3);
            n_end = scfg * ncfg * ((dcfg == 0) ? 100 : (dcfg == 1) ? 2 : dcfg);
            ab    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n_end + 1) : 0;
            run_frame($sformatf("rand%0d", r), dcfg, scfg, ncfg, ab, 1'b0,
                      $urandom_range(0, 1) ? $urandom_range(1, 20) : -1);
            if ($urandom_range(0, 1) == 1) idle($sformatf("rand%0d_gap", r), $urandom_range(1, 3));
        end
        idle("final_idle", 3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
